// File: rtl/sdram_arbiter_pkg.sv
// Shared types and helpers for the two-client SDRAM user-port arbiter.
// Client indices, FSM encoding and the latched request slot layout live here.
package sdram_arbiter_pkg;

    localparam int SD_ADDR_W = 32;
    localparam int SD_DATA_W = 32;

    localparam logic CLIENT_DISPLAY = 1'b0;
    localparam logic CLIENT_DRAWER  = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [SD_ADDR_W-1:0] addr;
        logic                 rw;
        logic [SD_DATA_W-1:0] data;
        logic                 wmask;
    } req_slot_t;

    // The display wins unless the drawer is pending and has been passed over too often.
    function automatic logic pick_client(input logic pend0, input logic pend1, input logic starve_ok);
        if (pend0 && (!pend1 || starve_ok)) begin
            return CLIENT_DISPLAY;
        end else begin
            return CLIENT_DRAWER;
        end
    endfunction

endpackage

// File: rtl/sdram_req_slot.sv
// One client's request holding slot: pending flag, latched request, sticky overrun.
// A capture coinciding with the completion clear is accepted as a fresh request.
module sdram_req_slot
    import sdram_arbiter_pkg::*;
(
    input  logic      clock,
    input  logic      reset,
    input  logic      capture,
    input  logic      clear,
    input  req_slot_t req_in,
    output logic      pending,
    output req_slot_t slot,
    output logic      overrun
);

    logic      pending_q, pending_d;
    req_slot_t slot_q, slot_d;
    logic      overrun_q, overrun_d;

    // Next-state for the slot: accept, flag a dropped request, or release on completion.
    always_comb begin
        pending_d = pending_q;
        slot_d    = slot_q;
        overrun_d = overrun_q;
        if (capture && (!pending_q || clear)) begin
            pending_d = 1'b1;
            slot_d    = req_in;
        end else if (capture) begin
            overrun_d = 1'b1;
        end else if (clear) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Slot registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            pending_q <= 1'b0;
            slot_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
            slot_q    <= slot_d;
            overrun_q <= overrun_d;
        end
    end

    assign pending = pending_q;
    assign slot    = slot_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/sdram_arbiter.sv
// Two-client arbiter for the SDRAM user port: display (client 0) has priority,
// drawer (client 1) is guaranteed a grant after STARVE_MAX consecutive display grants.
module sdram_arbiter
    import sdram_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4,
    parameter int ADDR_W     = SD_ADDR_W,
    parameter int DATA_W     = SD_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] in_c0_addr,
    input  logic              in_c0_rw,
    input  logic [DATA_W-1:0] in_c0_data_in,
    input  logic              in_c0_wmask,
    input  logic              in_c0_in_valid,
    output logic [DATA_W-1:0] out_c0_data_out,
    output logic              out_c0_done,
    output logic              out_c0_overrun,
    input  logic [ADDR_W-1:0] in_c1_addr,
    input  logic              in_c1_rw,
    input  logic [DATA_W-1:0] in_c1_data_in,
    input  logic              in_c1_wmask,
    input  logic              in_c1_in_valid,
    output logic [DATA_W-1:0] out_c1_data_out,
    output logic              out_c1_done,
    output logic              out_c1_overrun,
    output logic [ADDR_W-1:0] out_sd_addr,
    output logic              out_sd_rw,
    output logic [DATA_W-1:0] out_sd_data_in,
    output logic              out_sd_wmask,
    output logic              out_sd_in_valid,
    input  logic [DATA_W-1:0] in_sd_data_out,
    input  logic              in_sd_done
);

    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    req_slot_t req_c0, req_c1, slot_c0, slot_c1, sel;
    logic      pend_c0, pend_c1, clear_c0, clear_c1, winner;

    arb_state_t        state_q, state_d;
    logic              owner_q, owner_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
    logic              sd_rw_q, sd_rw_d;
    logic [DATA_W-1:0] sd_data_q, sd_data_d;
    logic              sd_wmask_q, sd_wmask_d;
    logic              sd_valid_q, sd_valid_d;
    logic              c0_done_q, c0_done_d, c1_done_q, c1_done_d;
    logic [DATA_W-1:0] c0_data_q, c0_data_d, c1_data_q, c1_data_d;

    assign req_c0 = '{addr: SD_ADDR_W'(in_c0_addr), rw: in_c0_rw,
                      data: SD_DATA_W'(in_c0_data_in), wmask: in_c0_wmask};
    assign req_c1 = '{addr: SD_ADDR_W'(in_c1_addr), rw: in_c1_rw,
                      data: SD_DATA_W'(in_c1_data_in), wmask: in_c1_wmask};

    sdram_req_slot u_slot_c0 (
        .clock   (clock),
        .reset   (reset),
        .capture (in_c0_in_valid),
        .clear   (clear_c0),
        .req_in  (req_c0),
        .pending (pend_c0),
        .slot    (slot_c0),
        .overrun (out_c0_overrun)
    );

    sdram_req_slot u_slot_c1 (
        .clock   (clock),
        .reset   (reset),
        .capture (in_c1_in_valid),
        .clear   (clear_c1),
        .req_in  (req_c1),
        .pending (pend_c1),
        .slot    (slot_c1),
        .overrun (out_c1_overrun)
    );

    // Arbitration FSM: issue one transaction from IDLE, route completion back from WAIT.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        sd_addr_d  = sd_addr_q;
        sd_rw_d    = sd_rw_q;
        sd_data_d  = sd_data_q;
        sd_wmask_d = sd_wmask_q;
        sd_valid_d = 1'b0;
        c0_done_d  = 1'b0;
        c1_done_d  = 1'b0;
        c0_data_d  = c0_data_q;
        c1_data_d  = c1_data_q;
        clear_c0   = 1'b0;
        clear_c1   = 1'b0;
        winner     = pick_client(pend_c0, pend_c1, starve_q < STARVE_LIM);
        sel        = (winner == CLIENT_DRAWER) ? slot_c1 : slot_c0;
        case (state_q)
            ST_IDLE: begin
                if (pend_c0 || pend_c1) begin
                    sd_addr_d  = ADDR_W'(sel.addr);
                    sd_rw_d    = sel.rw;
                    sd_data_d  = DATA_W'(sel.data);
                    sd_wmask_d = sel.wmask;
                    sd_valid_d = 1'b1;
                    owner_d    = winner;
                    state_d    = ST_WAIT;
                    if (winner == CLIENT_DRAWER) begin
                        starve_d = {SW{1'b0}};
                    end else if (pend_c1 && (starve_q < STARVE_LIM)) begin
                        starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
                    end else begin
                        starve_d = starve_q;
                    end
                end else begin
                    sd_rw_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (in_sd_done) begin
                    if (owner_q == CLIENT_DRAWER) begin
                        c1_done_d = 1'b1;
                        c1_data_d = in_sd_data_out;
                        clear_c1  = 1'b1;
                    end else begin
                        c0_done_d = 1'b1;
                        c0_data_d = in_sd_data_out;
                        clear_c0  = 1'b1;
                    end
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and registered output stage; reset abandons any transaction in flight.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            owner_q    <= CLIENT_DISPLAY;
            starve_q   <= {SW{1'b0}};
            sd_addr_q  <= {ADDR_W{1'b0}};
            sd_rw_q    <= 1'b1;
            sd_data_q  <= {DATA_W{1'b0}};
            sd_wmask_q <= 1'b0;
            sd_valid_q <= 1'b0;
            c0_done_q  <= 1'b0;
            c1_done_q  <= 1'b0;
            c0_data_q  <= {DATA_W{1'b0}};
            c1_data_q  <= {DATA_W{1'b0}};
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            sd_addr_q  <= sd_addr_d;
            sd_rw_q    <= sd_rw_d;
            sd_data_q  <= sd_data_d;
            sd_wmask_q <= sd_wmask_d;
            sd_valid_q <= sd_valid_d;
            c0_done_q  <= c0_done_d;
            c1_done_q  <= c1_done_d;
            c0_data_q  <= c0_data_d;
            c1_data_q  <= c1_data_d;
        end
    end

    assign out_sd_addr     = sd_addr_q;
    assign out_sd_rw       = sd_rw_q;
    assign out_sd_data_in  = sd_data_q;
    assign out_sd_wmask    = sd_wmask_q;
    assign out_sd_in_valid = sd_valid_q;
    assign out_c0_done     = c0_done_q;
    assign out_c1_done     = c1_done_q;
    assign out_c0_data_out = c0_data_q;
    assign out_c1_data_out = c1_data_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: latency, routing, priority, anti-starvation,
// overrun and mid-transaction reset, with hand-computed expectations.
module tb_sdram_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] in_c0_addr = 32'd0, in_c1_addr = 32'd0;
    logic        in_c0_rw = 1'b0, in_c1_rw = 1'b0;
    logic [31:0] in_c0_data_in = 32'd0, in_c1_data_in = 32'd0;
    logic        in_c0_wmask = 1'b0, in_c1_wmask = 1'b0;
    logic        in_c0_in_valid = 1'b0, in_c1_in_valid = 1'b0;
    logic [31:0] out_c0_data_out, out_c1_data_out;
    logic        out_c0_done, out_c1_done, out_c0_overrun, out_c1_overrun;
    logic [31:0] out_sd_addr, out_sd_data_in;
    logic        out_sd_rw, out_sd_wmask, out_sd_in_valid;
    logic [31:0] in_sd_data_out = 32'd0;
    logic        in_sd_done = 1'b0;

    int total = 0;
    int bad   = 0;
    int n_pulses = 0;
    int base;

    sdram_arbiter #(.STARVE_MAX(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset),
        .in_c0_addr(in_c0_addr), .in_c0_rw(in_c0_rw), .in_c0_data_in(in_c0_data_in),
        .in_c0_wmask(in_c0_wmask), .in_c0_in_valid(in_c0_in_valid),
        .out_c0_data_out(out_c0_data_out), .out_c0_done(out_c0_done),
        .out_c0_overrun(out_c0_overrun),
        .in_c1_addr(in_c1_addr), .in_c1_rw(in_c1_rw), .in_c1_data_in(in_c1_data_in),
        .in_c1_wmask(in_c1_wmask), .in_c1_in_valid(in_c1_in_valid),
        .out_c1_data_out(out_c1_data_out), .out_c1_done(out_c1_done),
        .out_c1_overrun(out_c1_overrun),
        .out_sd_addr(out_sd_addr), .out_sd_rw(out_sd_rw), .out_sd_data_in(out_sd_data_in),
        .out_sd_wmask(out_sd_wmask), .out_sd_in_valid(out_sd_in_valid),
        .in_sd_data_out(in_sd_data_out), .in_sd_done(in_sd_done)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (reset && out_sd_in_valid) n_pulses <= n_pulses + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_sd_valid"}, out_sd_in_valid, 64'd0);
        chk({tag, "_sd_rw"}, out_sd_rw, 64'd1);
        chk({tag, "_sd_addr"}, out_sd_addr, 64'd0);
        chk({tag, "_sd_data"}, out_sd_data_in, 64'd0);
        chk({tag, "_sd_wmask"}, out_sd_wmask, 64'd0);
        chk({tag, "_dones"}, {out_c0_done, out_c1_done}, 64'd0);
        chk({tag, "_data0"}, out_c0_data_out, 64'd0);
        chk({tag, "_data1"}, out_c1_data_out, 64'd0);
        chk({tag, "_overruns"}, {out_c0_overrun, out_c1_overrun}, 64'd0);
    endtask

    // Wait (bounded) for an issue, check its address, then complete it.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic exp_client,
                         input logic [31:0] rdata, input logic rereq0);
        int n = 0;
        while (!out_sd_in_valid && n < 20) begin
            step();
            n++;
        end
        chk({tag, "_issue"}, out_sd_in_valid, 64'd1);
        chk({tag, "_addr"}, out_sd_addr, {32'd0, exp_addr});
        step();
        in_sd_done = 1'b1;
        in_sd_data_out = rdata;
        if (rereq0) in_c0_in_valid = 1'b1;
        step();
        in_sd_done = 1'b0;
        in_c0_in_valid = 1'b0;
        chk({tag, "_done"}, exp_client ? {out_c1_done, out_c0_done} : {out_c0_done, out_c1_done},
            64'd2);
    endtask

    initial begin
        step();
        step();
        chk_reset_state("reset");
        reset = 1'b1;
        step();

        // Single write from client 1.
        in_c1_addr = 32'h40C0_0000; in_c1_data_in = 32'h00FF_00FF;
        in_c1_rw = 1'b1; in_c1_wmask = 1'b1; in_c1_in_valid = 1'b1;
        step();
        in_c1_in_valid = 1'b0;
        chk("w1_not_yet", out_sd_in_valid, 64'd0);
        step();
        chk("w1_issue", out_sd_in_valid, 64'd1);
        chk("w1_addr", out_sd_addr, 64'h40C0_0000);
        chk("w1_data", out_sd_data_in, 64'h00FF_00FF);
        chk("w1_rw_wmask", {out_sd_rw, out_sd_wmask}, 64'd3);
        step();
        chk("w1_one_pulse", out_sd_in_valid, 64'd0);
        in_sd_done = 1'b1;
        step();
        in_sd_done = 1'b0;
        chk("w1_done", {out_c1_done, out_c0_done}, 64'd2);
        step();
        chk("w1_done_gone", {out_c1_done, out_c0_done}, 64'd0);

        // Read from client 0.
        in_c0_addr = 32'h0000_0100; in_c0_rw = 1'b0; in_c0_wmask = 1'b0; in_c0_in_valid = 1'b1;
        step();
        in_c0_in_valid = 1'b0;
        step();
        chk("r0_issue", out_sd_in_valid, 64'd1);
        chk("r0_rw_issue", out_sd_rw, 64'd0);
        chk("r0_addr", out_sd_addr, 64'h100);
        step();
        chk("r0_rw_wait", out_sd_rw, 64'd0);
        in_sd_done = 1'b1; in_sd_data_out = 32'h1234_5678;
        step();
        in_sd_done = 1'b0; in_sd_data_out = 32'hDEAD_BEEF;
        chk("r0_done", {out_c0_done, out_c1_done}, 64'd2);
        chk("r0_data", out_c0_data_out, 64'h1234_5678);
        step();
        chk("r0_data_hold", out_c0_data_out, 64'h1234_5678);
        chk("r0_rw_idle", out_sd_rw, 64'd1);

        // Simultaneous requests: client 0 first, then client 1.
        base = n_pulses;
        in_c0_addr = 32'h0000_1000; in_c1_addr = 32'h0000_2000;
        in_c0_in_valid = 1'b1; in_c1_in_valid = 1'b1;
        step();
        in_c0_in_valid = 1'b0; in_c1_in_valid = 1'b0;
        serve("sim_a", 32'h0000_1000, 1'b0, 32'hA5A5_0000, 1'b0);
        chk("sim_a_data", out_c0_data_out, 64'hA5A5_0000);
        serve("sim_b", 32'h0000_2000, 1'b1, 32'h5A5A_0001, 1'b0);
        chk("sim_b_data", out_c1_data_out, 64'h5A5A_0001);
        step(); step(); step();
        chk("sim_pulses", n_pulses - base, 64'd2);

        // Anti-starvation: expected grant order 0,0,0,0,1,0.
        in_c0_in_valid = 1'b1; in_c1_in_valid = 1'b1;
        step();
        in_c0_in_valid = 1'b0; in_c1_in_valid = 1'b0;
        serve("stv_g1", 32'h0000_1000, 1'b0, 32'd1, 1'b1);
        serve("stv_g2", 32'h0000_1000, 1'b0, 32'd2, 1'b1);
        serve("stv_g3", 32'h0000_1000, 1'b0, 32'd3, 1'b1);
        serve("stv_g4", 32'h0000_1000, 1'b0, 32'd4, 1'b1);
        serve("stv_g5", 32'h0000_2000, 1'b1, 32'd5, 1'b0);
        serve("stv_g6", 32'h0000_1000, 1'b0, 32'd6, 1'b0);
        step(); step();

        // Overrun on client 1.
        base = n_pulses;
        chk("ovr_clear_before", out_c1_overrun, 64'd0);
        in_c1_addr = 32'h0000_3000; in_c1_in_valid = 1'b1;
        step();
        in_c1_in_valid = 1'b0;
        step();
        chk("ovr_issue", out_sd_in_valid, 64'd1);
        in_c1_addr = 32'h0000_4000; in_c1_in_valid = 1'b1;
        step();
        in_c1_in_valid = 1'b0;
        chk("ovr_flag", out_c1_overrun, 64'd1);
        chk("ovr_addr_kept", out_sd_addr, 64'h3000);
        in_sd_done = 1'b1;
        step();
        in_sd_done = 1'b0;
        chk("ovr_done", out_c1_done, 64'd1);
        step(); step(); step(); step();
        chk("ovr_pulses", n_pulses - base, 64'd1);
        chk("ovr_sticky", out_c1_overrun, 64'd1);

        // Reset during WAIT abandons the transaction.
        in_c0_addr = 32'h0000_5000; in_c0_in_valid = 1'b1;
        step();
        in_c0_in_valid = 1'b0;
        step();
        chk("rst_issue", out_sd_in_valid, 64'd1);
        step();
        reset = 1'b0; in_sd_done = 1'b1; in_sd_data_out = 32'hCAFE_F00D;
        step();
        chk_reset_state("rst_mid");
        reset = 1'b1; in_sd_done = 1'b0;
        step();
        chk("rst_no_done", {out_c0_done, out_c1_done}, 64'd0);
        chk("rst_no_issue", out_sd_in_valid, 64'd0);
        in_c1_addr = 32'h0000_6000; in_c1_in_valid = 1'b1;
        step();
        in_c1_in_valid = 1'b0;
        serve("rst_after", 32'h0000_6000, 1'b1, 32'h0BAD_F00D, 1'b0);
        chk("rst_after_data", out_c1_data_out, 64'h0BAD_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
